// File: rtl/banco_registradores_pkg.sv
// ============================================================================
//  Module  : banco_pkg
//  Purpose : Shared defaults and dump-FSM state encoding for the MIPS
//            32x32 register file and its bus interface.
//  Contents: WIDTH / DEPTH / ADDR_W defaults, dump_state_e enum.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package banco_pkg;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_RUN  = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

`default_nettype wire

// File: rtl/banco_registradores_if.sv
// ============================================================================
//  Module  : banco_registradores_if
//  Purpose : Bundles the write port, both read ports and the dump stream of
//            the register file.
//  Modports: master - drives wr_*, rd_addr_*, dump_start; observes results
//            slave  - the register file itself
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface banco_registradores_if #(
  parameter int WIDTH = banco_pkg::WIDTH,
  parameter int DEPTH = banco_pkg::DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [WIDTH-1:0]  dump_data;

  modport master (
    output wr_enable, wr_addr, wr_data, rd_addr_a, rd_addr_b, dump_start,
    input  rd_data_a, rd_data_b, dump_busy, dump_valid, dump_addr, dump_data
  );

  modport slave (
    input  wr_enable, wr_addr, wr_data, rd_addr_a, rd_addr_b, dump_start,
    output rd_data_a, rd_data_b, dump_busy, dump_valid, dump_addr, dump_data
  );

endinterface

`default_nettype wire

// File: rtl/banco_registradores.sv
// ============================================================================
//  Module  : banco_registradores
//  Purpose : MIPS 32x32 register file. One write port, two registered read
//            ports with write-through bypass, and a dump port streaming every
//            register out once per cycle.
//  Ports   : ck             - clock, rising edge
//            reset_register - synchronous, active-low reset
//            bus            - banco_registradores_if.slave (write, reads, dump)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module banco_registradores #(
  parameter int WIDTH = banco_pkg::WIDTH,
  parameter int DEPTH = banco_pkg::DEPTH
) (
  input  wire logic               ck,
  input  wire logic               reset_register,
  banco_registradores_if.slave    bus
);
  import banco_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = DUMP_IDLE;
  localparam logic [1:0] S_RUN  = DUMP_RUN;
  localparam logic [1:0] S_DONE = DUMP_DONE;

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  // Flip-flop array: three reads per cycle plus a full clear on reset rule
  // out a RAM macro.
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_rd_a;
  logic [WIDTH-1:0]  r_rd_b;
  logic              r_busy;
  logic              r_valid;
  logic [ADDR_W-1:0] r_dump_addr;
  logic [WIDTH-1:0]  r_dump_data;

  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;
  logic [WIDTH-1:0]  w_rd_dump;
  logic              w_wr_ok;

  // r0 is hard zero; a same-edge write to the address being read is forwarded
  // so the reader sees the word that lands at this edge.
  function automatic logic [WIDTH-1:0] f_rd(
    input logic [ADDR_W-1:0] a,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd,
    input logic [WIDTH-1:0]  stored
  );
    if (a == '0)
      return '0;
    else if (we && (wa == a))
      return wd;
    else
      return stored;
  endfunction

  always_comb begin
    w_wr_ok   = bus.wr_enable && (bus.wr_addr != '0);
    w_rd_a    = f_rd(bus.rd_addr_a, bus.wr_enable, bus.wr_addr, bus.wr_data, r_mem[bus.rd_addr_a]);
    w_rd_b    = f_rd(bus.rd_addr_b, bus.wr_enable, bus.wr_addr, bus.wr_data, r_mem[bus.rd_addr_b]);
    w_rd_dump = f_rd(r_cnt,         bus.wr_enable, bus.wr_addr, bus.wr_data, r_mem[r_cnt]);
  end

  // Storage
  always_ff @(posedge ck) begin
    if (!reset_register) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read ports: registered every cycle, no enable
  always_ff @(posedge ck) begin
    if (!reset_register) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= w_rd_a;
      r_rd_b <= w_rd_b;
    end
  end

  // Dump FSM; dump_start is only looked at in IDLE, so pulses during a dump
  // are simply dropped.
  always_ff @(posedge ck) begin
    if (!reset_register) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_dump_addr <= '0;
      r_dump_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.dump_start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_valid     <= 1'b1;
          r_dump_addr <= r_cnt;
          r_dump_data <= w_rd_dump;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == c_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data_a  = r_rd_a;
  assign bus.rd_data_b  = r_rd_b;
  assign bus.dump_busy  = r_busy;
  assign bus.dump_valid = r_valid;
  assign bus.dump_addr  = r_dump_addr;
  assign bus.dump_data  = r_dump_data;

endmodule

`default_nettype wire

// File: tb/tb_banco_registradores.sv
// ============================================================================
//  Module  : tb_banco_registradores
//  Purpose : Self-checking bench for banco_registradores. Read results and
//            dump beats are queued as expectations when stimulus is applied
//            and compared when the DUT presents them.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_banco_registradores;
  import banco_pkg::*;

  logic ck = 1'b0;
  logic reset_register;
  int   n_tests = 0;
  int   n_fail  = 0;

  banco_registradores_if bus ();

  banco_registradores dut (
    .ck             (ck),
    .reset_register (reset_register),
    .bus            (bus)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } beat_t;

  beat_t             q_dump [$];
  logic [WIDTH-1:0]  q_rd_a [$];
  logic [WIDTH-1:0]  q_rd_b [$];
  beat_t             mon_beat;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of write/read stimulus; optionally queue and then check
  // the read results registered at this edge.
  task automatic drive(input string tag,
                       input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                       input bit exp_en, input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
    bus.wr_enable = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    if (exp_en) begin
      q_rd_a.push_back(ea);
      q_rd_b.push_back(eb);
    end
    @(posedge ck);
    #1;
    if (exp_en) begin
      chk({tag, "_a"}, bus.rd_data_a, q_rd_a.pop_front());
      chk({tag, "_b"}, bus.rd_data_b, q_rd_b.pop_front());
    end
  endtask

  task automatic idle();
    drive("idle", 1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // Dump monitor: every presented beat must match the head of the queue
  always @(negedge ck) begin
    if (bus.dump_valid === 1'b1) begin
      if (q_dump.size() == 0) begin
        chk("dump_unexpected_beat", 32'(bus.dump_valid), 32'd0);
      end else begin
        mon_beat = q_dump.pop_front();
        chk("dump_addr", 32'(bus.dump_addr), 32'(mon_beat.addr));
        chk("dump_data", bus.dump_data, mon_beat.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset_register = 1'b0;
    bus.wr_enable  = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_addr_a  = '0;
    bus.rd_addr_b  = '0;
    bus.dump_start = 1'b0;
    idle();
    reset_register = 1'b1;

    // ---- reset clears storage and outputs
    drive("wr_r5_aa", 1'b1, 5'd5, 32'h0000_00AA, 5'd5, 5'd5, 1'b0, '0, '0);
    drive("pre_rst_rd", 1'b0, '0, '0, 5'd5, 5'd5, 1'b1, 32'h0000_00AA, 32'h0000_00AA);
    reset_register = 1'b0;
    drive("rst1", 1'b0, '0, '0, 5'd5, 5'd5, 1'b0, '0, '0);
    drive("rst2", 1'b0, '0, '0, 5'd5, 5'd5, 1'b0, '0, '0);
    chk("rst_rd_a",       bus.rd_data_a, '0);
    chk("rst_rd_b",       bus.rd_data_b, '0);
    chk("rst_dump_busy",  32'(bus.dump_busy), '0);
    chk("rst_dump_valid", 32'(bus.dump_valid), '0);
    chk("rst_dump_addr",  32'(bus.dump_addr), '0);
    chk("rst_dump_data",  bus.dump_data, '0);
    reset_register = 1'b1;
    drive("post_rst_r5", 1'b0, '0, '0, 5'd5, 5'd5, 1'b1, 32'h0, 32'h0);

    // ---- write then read on both ports
    drive("wr_r5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, '0, '0);
    drive("rd_r5", 1'b0, '0, '0, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // ---- r0 is hard-wired zero, even with a same-cycle write to it
    drive("wr_r0_same", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
    drive("rd_r0",      1'b0, '0, '0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);

    // ---- bypass on port A, then on port B, then stored value
    drive("byp_a",  1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd5, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
    drive("byp_b",  1'b1, 5'd9, 32'h0000_0055, 5'd7, 5'd9, 1'b1, 32'h1234_5678, 32'h0000_0055);
    drive("rd_7_9", 1'b0, '0, '0, 5'd9, 5'd7, 1'b1, 32'h0000_0055, 32'h1234_5678);

    // ---- full dump with preload, ignored restart, write during dump
    for (int k = 1; k < 32; k++)
      drive("preload", 1'b1, 5'(k), 32'(k) * 32'h0101_0101, '0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 32; k++)
      q_dump.push_back('{5'(k), (k == 20) ? 32'hCAFE_0000 : 32'(k) * 32'h0101_0101});
    for (int i = 0; i <= 35; i++) begin
      bus.dump_start = (i == 0) || (i == 5);
      if (i == 10)
        drive("wr_r20_dump", 1'b1, 5'd20, 32'hCAFE_0000, '0, '0, 1'b0, '0, '0);
      else if (i == 3)
        drive("rd_during_dump", 1'b0, '0, '0, 5'd5, 5'd31, 1'b1, 32'h0505_0505, 32'h1F1F_1F1F);
      else
        idle();
      case (i)
        0:  begin chk("e0_busy",  32'(bus.dump_busy), 32'd1); chk("e0_valid",  32'(bus.dump_valid), 32'd0); end
        1:  begin chk("e1_busy",  32'(bus.dump_busy), 32'd1); chk("e1_valid",  32'(bus.dump_valid), 32'd1); end
        32: begin chk("e32_busy", 32'(bus.dump_busy), 32'd1); chk("e32_valid", 32'(bus.dump_valid), 32'd1); end
        33: begin chk("e33_busy", 32'(bus.dump_busy), 32'd0); chk("e33_valid", 32'(bus.dump_valid), 32'd0); end
        34: chk("e34_busy_no_requeue", 32'(bus.dump_busy), 32'd0);
        default: ;
      endcase
    end
    bus.dump_start = 1'b0;
    chk("dump_all_beats_seen", 32'(q_dump.size()), 32'd0);

    // ---- reset in the middle of a dump
    for (int k = 0; k <= 10; k++)
      q_dump.push_back('{5'(k), 32'(k) * 32'h0101_0101});
    for (int i = 0; i <= 11; i++) begin
      bus.dump_start = (i == 0);
      idle();
    end
    bus.dump_start = 1'b0;
    reset_register = 1'b0;
    idle();
    chk("midrst_busy",  32'(bus.dump_busy), '0);
    chk("midrst_valid", 32'(bus.dump_valid), '0);
    chk("midrst_addr",  32'(bus.dump_addr), '0);
    chk("midrst_data",  bus.dump_data, '0);
    chk("midrst_beats_seen", 32'(q_dump.size()), 32'd0);
    reset_register = 1'b1;
    idle();
    chk("midrst_no_resume", 32'(bus.dump_busy), '0);

    // ---- fresh dump after reset returns all zeros
    for (int k = 0; k < 32; k++)
      q_dump.push_back('{5'(k), 32'h0});
    for (int i = 0; i <= 34; i++) begin
      bus.dump_start = (i == 0);
      idle();
    end
    bus.dump_start = 1'b0;
    chk("zero_dump_beats_seen", 32'(q_dump.size()), 32'd0);
    chk("zero_dump_idle", 32'(bus.dump_busy), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/banco_registradores.md
# banco_registradores

MIPS 32×32 general-purpose register file: one write port, two synchronous read ports and a sequential dump port that streams all registers out one per cycle. It is the read-side counterpart of the enable/reset datapath register. The write port is the same enable-gated capture. Reads return stored state to the ALU operand path, and the dump port feeds the bench/debug scoreboard.

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers; ADDR_W = $clog2(DEPTH) = 5
- ck  in  1  clock; all state updates on rising edge
- reset_register  in  1  synchronous, active-low reset
- wr_enable  in  1  write strobe
- wr_addr  in  ADDR_W  write register index
- wr_data  in  WIDTH  write data
- rd_addr_a  in  ADDR_W  read port A index
- rd_data_a  out  WIDTH  read port A data, registered
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_b  out  WIDTH  read port B data, registered
- dump_start  in  1  request full-file dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump beat present
- dump_addr  out  ADDR_W  index of current beat
- dump_data  out  WIDTH  contents of dump_addr

## Operation
- Reset (reset_register=0 at an edge) sets every storage word to 0 and every output to 0. The FSM goes to IDLE and the dump counter to 0. Reset overrides all other inputs.
- Write: at an edge with reset_register=1, wr_enable=1 and wr_addr≠0, wr_data is stored. Writes to index 0 are discarded; r0 always reads 0.
- Read function rd(x): 0 if x=0; else wr_data if wr_enable=1 and wr_addr=x (write-through bypass); else mem[x].
- Ports A and B register rd(rd_addr_a) and rd(rd_addr_b) every non-reset edge, with no enable. A=B addressing is legal.
- Dump FSM states are IDLE, RUN and DONE:
  - IDLE: on dump_start=1, go to RUN with cnt=0 and dump_busy<=1. Otherwise hold.
  - RUN: each edge sets dump_valid<=1, dump_addr<=cnt, dump_data<=rd(cnt) (bypass applies) and cnt<=cnt+1. The edge that presents cnt=DEPTH-1 goes to DONE.
  - DONE: next edge sets dump_valid<=0 and dump_busy<=0 and returns to IDLE.
- dump_start is sampled only in IDLE. It is ignored in RUN and DONE, with no queuing.
- cnt is ADDR_W bits. It never wraps inside a dump because the exit occurs at DEPTH-1.
- Read ports and the write port stay fully operational during a dump.

## Timing
- Write latency: the word is stored at the edge where wr_enable is sampled. A read of that address registered at the same edge returns the new data, through the bypass.
- Read latency: 1 cycle, from address at edge E to data valid after E.
- Dump, with dump_start sampled at edge E0:
  - dump_busy is high after E0 through after E32 and drops at E33.
  - dump_valid is high after E1 through after E32, giving 32 consecutive beats with dump_addr 0..31 in order.
  - The earliest next accepted dump_start is sampled at E34.
- A write to register k at an edge before the beat-k edge is reflected in the dump. A write at the same edge is also reflected, through the bypass. A later write is not.
- Reset mid-dump: at that edge all dump outputs become 0, the FSM goes to IDLE and the dump is abandoned with no partial completion.

## Structure
- Shared package banco_pkg holds WIDTH/DEPTH/ADDR_W defaults and the dump state enum (IDLE, RUN, DONE).
- One module, no sub-module. Storage is a flip-flop array, not an inferred RAM, because the file has 3 read accesses per cycle and is cleared by reset.

## Test plan
- Reset: write r5=0x0000_00AA, then hold reset_register=0 for 2 edges. All outputs are 0, and a later read of r5 returns 0x0000_0000.
- Write/read: write r5=0xDEAD_BEEF, then read rd_addr_a=5 and rd_addr_b=5 the next cycle. Both ports return 0xDEAD_BEEF one cycle after the address.
- r0: wr_enable=1, wr_addr=0, wr_data=0xFFFF_FFFF. A read of r0 returns 0x0000_0000 on both ports.
- Bypass: in the same cycle drive wr r7=0x1234_5678 and rd_addr_a=7, with r7 previously 0. rd_data_a=0x1234_5678 after that edge.
- Dump:
  - Preload rk=k·0x0101_0101 for k=1..31, then pulse dump_start. Expect 32 beats, addr 0..31, data 0, 0x0101_0101 … 0x1F1F_1F1F.
  - Check busy/valid edges at E0/E1/E33.
  - dump_start pulsed at E5 is ignored.
  - A write of r20=0xCAFE_0000 at E10 appears on beat 20.
- Reset mid-dump: assert reset_register=0 at the edge after beat 10 is presented. dump_valid/busy/addr/data are all 0 after that edge, and a new dump_start returns all-zero data.
